or_issue_unit: RTL and testbench
================================

Name: or_issue_unit

Overview:
- Upstream operand and issue stage for the 4-bit bitwise_or unit.
- Holds a small register file and accepts a 3-address OR instruction through a valid/ready handshake.
- Drives the two operand registers that feed bitwise_or's in1/in2, captures bitwise_or's output, and writes it back to the destination register.
- Sequenced by a 4-state FSM; one instruction is in flight at a time.

Parameters:
- WIDTH, 4, datapath width; must match bitwise_or operand width.
- NREGS, 4, number of register-file entries; power of two, at least 2.
- AW, 2, register address width; equals log2(NREGS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  external register load strobe.
- wr_addr  input  AW  external load address.
- wr_data  input  WIDTH  external load data.
- issue_valid  input  1  instruction offered.
- issue_ready  output  1  unit can accept an instruction.
- src1  input  AW  first source register.
- src2  input  AW  second source register.
- dst  input  AW  destination register.
- op_a  output  WIDTH  registered operand; drives bitwise_or in1.
- op_b  output  WIDTH  registered operand; drives bitwise_or in2.
- alu_result  input  WIDTH  bitwise_or output.
- done  output  1  one-cycle completion pulse.
- rd_addr  input  AW  debug read address.
- rd_data  output  WIDTH  combinational read of regs[rd_addr].

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all regs=0; op_a=op_b=0; internal result_q=0; done=0.
  - Latched src1/src2/dst=0.
  - Reset asserted mid-operation aborts the instruction; no writeback occurs.
- issue_ready = (state==IDLE), purely combinational from state.
- Accept happens at a rising edge with issue_valid && issue_ready.
  - At that edge: latch src1, src2, dst; state goes to FETCH.
  - issue_valid while not ready is ignored; no queuing.
- FSM, one transition per edge:
  - IDLE -> FETCH on accept; otherwise stays in IDLE.
  - FETCH: op_a<=regs[src1_q], op_b<=regs[src2_q]; -> EXEC.
  - EXEC: result_q<=alu_result (the combinational OR of op_a/op_b); -> WB.
  - WB: regs[dst_q]<=result_q; done<=1; -> IDLE.
- Latency:
  - Accept edge E0; op_a/op_b valid after E1; writeback at E3.
  - done is high for exactly the cycle after E3, and issue_ready is high in that same cycle.
  - Back-to-back: the next accept is possible at E4, giving a throughput of one instruction per 4 cycles.
- done deasserts at the next edge unless another WB edge occurs; it is never high for two consecutive cycles.
- op_a/op_b hold their values outside FETCH.
- External load (wr_en):
  - Honoured only when state==IDLE; ignored in FETCH/EXEC/WB.
  - wr_en on the same edge as an accept: the write happens, and the subsequent FETCH reads the newly written value.
- Aliasing: src1==src2 and/or dst==src are legal. Operands are read at FETCH, before the WB write.
- Widths: all data is WIDTH bits; no carry or extension.
- Register addresses never exceed NREGS-1 when AW matches NREGS.

Test Plan:
- Load r1=0100, r2=0011; issue src1=1, src2=2, dst=3 -> after E1 op_a=0100, op_b=0011; done pulses one cycle after E3; rd_addr=3 reads 0111.
- Load r0=1111, r1=1000; issue src1=1, src2=0, dst=1 -> r1=1111; r0 still 1111.
- Alias case: r2=0101; issue src1=2, src2=2, dst=2 -> r2 stays 0101; done asserts exactly once.
- Issue while busy, plus wr_en during EXEC: second issue_valid is ignored; the write to r0 is ignored; only one done pulse.
- wr_en r1=0100 on the same edge as an accept that uses src1=1 with r2=0101 -> result is 0101 (0100|0101).
- Assert reset during EXEC -> outputs and regs return to 0 immediately; no done; issue_ready=1 after reset is released.

Source files
------------

// File: rtl/or_issue_unit.sv
// Operand/issue stage for the bitwise_or unit: a small register file, a valid/ready
// instruction port and a four-state IDLE/FETCH/EXEC/WB sequencer with one op in flight.
module or_issue_unit #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [AW-1:0]    src1,
    input  logic [AW-1:0]    src2,
    input  logic [AW-1:0]    dst,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AW-1:0]    src1_q, src1_d;
    logic [AW-1:0]    src2_q, src2_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic             done_q, done_d;
    logic             accept;

    assign issue_ready = (state_q == IDLE);
    assign accept      = issue_valid && issue_ready;

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic; external loads only land while idle
    always_comb begin
        // NOTE: every comb output gets a hold/default value first so no latch is inferred.
        regs_d   = regs_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) regs_d[wr_addr] = wr_data;
                if (accept) begin
                    src1_d = src1;
                    src2_d = src2;
                    dst_d  = dst;
                end
            end
            FETCH: begin
                op_a_d = regs_q[src1_q];
                op_b_d = regs_q[src2_q];
            end
            EXEC:    result_d = alu_result;
            WB: begin
                regs_d[dst_q] = result_q;
                done_d        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is a handful of flops that must read zero after reset,
            // so it is cleared here rather than left to power-up contents like a RAM.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            done_q   <= done_d;
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign done    = done_q;
    assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_or_issue_unit.sv
// Directed bench for or_issue_unit; a plain OR stands in for the downstream bitwise_or unit.
module tb_or_issue_unit;

    localparam int WIDTH = 4;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             issue_valid;
    logic             issue_ready;
    logic [AW-1:0]    src1, src2, dst;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] alu_result;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    or_issue_unit #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .src1        (src1),
        .src2        (src2),
        .dst         (dst),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_result  (alu_result),
        .done        (done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    assign alu_result = op_a | op_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
        rd_addr = a;
        #1;
        check(tag, {28'd0, rd_data}, {28'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        next_cycle();
        wr_en = 1'b0;
    endtask

    // Issue one instruction and walk it through E0..E4, checking timing at each step.
    // Any wr_en the caller set up beforehand rides on the accept edge.
    task automatic do_issue(input string tag, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                            input logic [AW-1:0] d, input logic [WIDTH-1:0] exp_a,
                            input logic [WIDTH-1:0] exp_b);
        issue_valid = 1'b1; src1 = s1; src2 = s2; dst = d;
        next_cycle();                                   // E0
        issue_valid = 1'b0; wr_en = 1'b0;
        check({tag, "_busy"}, {31'd0, issue_ready}, 32'd0);
        next_cycle();                                   // E1
        check({tag, "_op_a"}, {28'd0, op_a}, {28'd0, exp_a});
        check({tag, "_op_b"}, {28'd0, op_b}, {28'd0, exp_b});
        check({tag, "_done_e1"}, {31'd0, done}, 32'd0);
        next_cycle();                                   // E2
        check({tag, "_done_e2"}, {31'd0, done}, 32'd0);
        next_cycle();                                   // E3
        check({tag, "_done_e3"}, {31'd0, done}, 32'd1);
        check({tag, "_ready_e3"}, {31'd0, issue_ready}, 32'd1);
        next_cycle();                                   // E4
        check({tag, "_done_e4"}, {31'd0, done}, 32'd0);
    endtask

    always @(negedge clk) if (done) n_done++;

    initial begin
        int base;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_valid = 1'b0; src1 = '0; src2 = '0; dst = '0; rd_addr = '0;
        #12;
        check("rst_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_op_a", {28'd0, op_a}, 32'd0);
        check("rst_op_b", {28'd0, op_b}, 32'd0);
        for (int i = 0; i < NREGS; i++) check_reg("rst_reg", AW'(i), 4'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // r1=0100 | r2=0011 -> r3=0111
        load(2'd1, 4'b0100);
        load(2'd2, 4'b0011);
        do_issue("t1", 2'd1, 2'd2, 2'd3, 4'b0100, 4'b0011);
        check_reg("t1_r3", 2'd3, 4'b0111);

        // r1 = r1 | r0 with r0=1111, r1=1000
        load(2'd0, 4'b1111);
        load(2'd1, 4'b1000);
        do_issue("t2", 2'd1, 2'd0, 2'd1, 4'b1000, 4'b1111);
        check_reg("t2_r1", 2'd1, 4'b1111);
        check_reg("t2_r0", 2'd0, 4'b1111);

        // Full aliasing: r2 = r2 | r2
        load(2'd2, 4'b0101);
        base = n_done;
        do_issue("t3", 2'd2, 2'd2, 2'd2, 4'b0101, 4'b0101);
        check_reg("t3_r2", 2'd2, 4'b0101);
        check("t3_one_done", n_done - base, 32'd1);

        // Busy: second issue ignored, wr_en during EXEC ignored. r3=0111 | r2=0101 -> r0
        base = n_done;
        issue_valid = 1'b1; src1 = 2'd3; src2 = 2'd2; dst = 2'd0;
        next_cycle();                                   // E0, now FETCH
        check("t4_busy", {31'd0, issue_ready}, 32'd0);
        src1 = 2'd1; src2 = 2'd1; dst = 2'd1;           // still valid, should be ignored
        next_cycle();                                   // E1, now EXEC
        check("t4_op_a", {28'd0, op_a}, 32'h7);
        check("t4_op_b", {28'd0, op_b}, 32'h5);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'b1010;
        next_cycle();                                   // E2, now WB
        wr_en = 1'b0; issue_valid = 1'b0;
        check("t4_done_e2", {31'd0, done}, 32'd0);
        next_cycle();                                   // E3
        check("t4_done_e3", {31'd0, done}, 32'd1);
        check_reg("t4_r0", 2'd0, 4'b0111);
        for (int i = 0; i < 5; i++) next_cycle();
        check("t4_one_done", n_done - base, 32'd1);
        check("t4_idle", {31'd0, issue_ready}, 32'd1);
        check_reg("t4_r1", 2'd1, 4'b1111);

        // wr_en r1=0100 on the accept edge; FETCH must see the new value. r2=0101 -> r3=0101
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'b0100;
        do_issue("t5", 2'd1, 2'd2, 2'd3, 4'b0100, 4'b0101);
        check_reg("t5_r3", 2'd3, 4'b0101);

        // Reset during EXEC: r0=0111 | r1=0100 would write 0111 to r2
        base = n_done;
        issue_valid = 1'b1; src1 = 2'd0; src2 = 2'd1; dst = 2'd2;
        next_cycle();                                   // E0
        issue_valid = 1'b0;
        next_cycle();                                   // E1, now EXEC
        check("t6_op_a_pre", {28'd0, op_a}, 32'h7);
        #2 reset = 1'b1;
        #1;
        check("t6_op_a", {28'd0, op_a}, 32'd0);
        check("t6_op_b", {28'd0, op_b}, 32'd0);
        check("t6_ready", {31'd0, issue_ready}, 32'd1);
        check_reg("t6_r0", 2'd0, 4'h0);
        check_reg("t6_r3", 2'd3, 4'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
        check("t6_no_done", n_done - base, 32'd0);
        check("t6_ready_post", {31'd0, issue_ready}, 32'd1);
        check_reg("t6_r2", 2'd2, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
